// File: rtl/on_off_pkg.sv
// Shared types and helpers for the on/off channel ramp.
// Contents:
//   ch_state_t   - per-channel ramp state (OFF, UP, ON, DOWN), derived from
//                  the gain counter and the target mode.
//   prod_width() - width of the signed sample*gain product.
package on_off_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } ch_state_t;

  // Signed sample (data_w) times a non-negative gain carried as a signed value
  // (ramp_log2 + 2 bits, including the extra sign bit).
  function automatic int prod_width(input int data_w, input int ramp_log2);
    return data_w + ramp_log2 + 2;
  endfunction

endpackage

// File: rtl/on_off_ramp_ch.sv
// One channel of the on/off ramp: gain counter, sample*gain scaling and
// status bits, with a two-stage pipeline.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - sample strobe; the gain only moves on strobed cycles
//   in_data     - signed input sample
//   mode        - target: 1 = ramp towards full scale, 0 = ramp towards zero
//   out_data    - (in_data * g) >>> RAMP_LOG2, held while no sample emerges
//   ch_active   - gain applied to out_data is non-zero
//   ch_settled  - gain is at the end point selected by mode
module on_off_ramp_ch
  import on_off_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RAMP_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  output logic [DATA_W-1:0] out_data,
  output logic              ch_active,
  output logic              ch_settled
);

  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = prod_width(DATA_W, RAMP_LOG2);
  localparam logic [GW-1:0] G_MAX = GW'(1 << RAMP_LOG2);

  // Stage 1: the gain counter itself plus the sample and mode it applies to.
  logic [GW-1:0]            g_reg, g_next;
  logic signed [DATA_W-1:0] x_s1_reg;
  logic                     mode_s1_reg;
  logic                     valid_s1_reg;

  ch_state_t                state_s1;
  logic signed [PW-1:0]     x_ext, g_ext, prod, shifted;

  // Counter step; direction follows mode immediately, so a reversal mid-ramp
  // simply continues from the current gain.
  always_comb begin
    g_next = g_reg;
    if (in_valid) begin
      if (mode && (g_reg < G_MAX)) begin
        g_next = g_reg + GW'(1);
      end else if (!mode && (g_reg != '0)) begin
        g_next = g_reg - GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_reg        <= '0;
      x_s1_reg     <= '0;
      mode_s1_reg  <= 1'b0;
      valid_s1_reg <= 1'b0;
    end else begin
      g_reg        <= g_next;
      valid_s1_reg <= in_valid;
      if (in_valid) begin
        x_s1_reg    <= $signed(in_data);
        mode_s1_reg <= mode;
      end
    end
  end

  // State of the sample sitting in stage 1 (gain after its own update).
  always_comb begin
    state_s1 = ST_OFF;
    if (mode_s1_reg) begin
      state_s1 = (g_reg == G_MAX) ? ST_ON : ST_UP;
    end else begin
      state_s1 = (g_reg == '0) ? ST_OFF : ST_DOWN;
    end
  end

  // Gain is carried with an explicit zero sign bit so the multiply stays
  // signed; at g = G_MAX the shift returns the input bit-exactly.
  always_comb begin
    x_ext   = PW'(x_s1_reg);
    g_ext   = PW'($signed({1'b0, g_reg}));
    prod    = x_ext * g_ext;
    shifted = prod >>> RAMP_LOG2;
  end

  // Stage 2: only loads on a valid sample, so data and status hold together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      ch_active  <= 1'b0;
      ch_settled <= 1'b1;
    end else if (valid_s1_reg) begin
      out_data   <= shifted[DATA_W-1:0];
      ch_active  <= (g_reg != '0);
      ch_settled <= (state_s1 == ST_OFF) || (state_s1 == ST_ON);
    end
  end

endmodule

// File: rtl/on_off_channel_ramp.sv
// Multi-channel on/off gate with a linear gain ramp per channel, placed
// between the modulator sample stream and the DAC interface.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - sample strobe (one sample per channel)
//   in_data     - NUM_CH packed signed samples, channel c at [c*DATA_W +: DATA_W]
//   mode        - per-channel target, 1 = on, 0 = off
//   out_valid   - in_valid delayed by two cycles
//   out_data    - ramped samples, same packing as in_data
//   ch_active   - per-channel: gain on current out_data is non-zero
//   ch_settled  - per-channel: ramp complete in the direction of mode
module on_off_channel_ramp
  import on_off_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 16,
  parameter int RAMP_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        mode,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        ch_active,
  output logic [NUM_CH-1:0]        ch_settled
);

  logic valid_s1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_reg <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      valid_s1_reg <= in_valid;
      out_valid    <= valid_s1_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    on_off_ramp_ch #(
      .DATA_W    (DATA_W),
      .RAMP_LOG2 (RAMP_LOG2)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data[gi*DATA_W +: DATA_W]),
      .mode       (mode[gi]),
      .out_data   (out_data[gi*DATA_W +: DATA_W]),
      .ch_active  (ch_active[gi]),
      .ch_settled (ch_settled[gi])
    );
  end

endmodule

// File: tb/tb_on_off_channel_ramp.sv
// Self-checking bench for on_off_channel_ramp (NUM_CH=2, DATA_W=16,
// RAMP_LOG2=4). Expected samples/status are computed when stimulus is driven,
// queued, and compared when out_valid presents them.
module tb_on_off_channel_ramp;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 16;
  localparam int G_MAX  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     in_valid = 1'b0;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH-1:0]        mode = '0;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        ch_active;
  logic [NUM_CH-1:0]        ch_settled;

  typedef struct {
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        act;
    logic [NUM_CH-1:0]        set;
  } exp_t;

  exp_t sb[$];
  int   g_model[NUM_CH];
  int   n_cmp = 0;
  int   n_err = 0;
  logic started = 1'b0;
  logic vd1, vd2;

  on_off_channel_ramp #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .RAMP_LOG2 (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .ch_active  (ch_active),
    .ch_settled (ch_settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference for the output strobe: in_valid seen two edges ago.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vd1 <= 1'b0;
      vd2 <= 1'b0;
    end else begin
      vd1 <= in_valid;
      vd2 <= vd1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", {63'b0, out_valid}, {63'b0, vd2});
      if (out_valid) begin
        check("sb_nonempty", {63'b0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", {32'b0, out_data}, {32'b0, e.data});
          check("ch_active", {62'b0, ch_active}, {62'b0, e.act});
          check("ch_settled", {62'b0, ch_settled}, {62'b0, e.set});
          $display("out: data=%0d/%0d act=%b set=%b",
                   $signed(out_data[DATA_W-1:0]), $signed(out_data[2*DATA_W-1:DATA_W]),
                   ch_active, ch_settled);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [NUM_CH-1:0] m,
                       input logic signed [DATA_W-1:0] x0,
                       input logic signed [DATA_W-1:0] x1);
    exp_t e;
    logic signed [DATA_W-1:0] xs[NUM_CH];
    int y;
    @(posedge clk);
    #1;
    in_valid = v;
    mode     = m;
    in_data  = {x1, x0};
    xs[0] = x0;
    xs[1] = x1;
    if (v) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m[c] && g_model[c] < G_MAX) g_model[c]++;
        else if (!m[c] && g_model[c] > 0) g_model[c]--;
        y = (int'(xs[c]) * g_model[c]) >>> 4;
        e.data[c*DATA_W +: DATA_W] = y[DATA_W-1:0];
        e.act[c] = (g_model[c] != 0);
        e.set[c] = m[c] ? (g_model[c] == G_MAX) : (g_model[c] == 0);
      end
      sb.push_back(e);
    end
  endtask

  // Asserts reset away from a clock edge and checks the clear is immediate.
  task automatic reset_now();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_data", {32'b0, out_data}, 64'd0);
    check("rst_ch_active", {62'b0, ch_active}, 64'd0);
    check("rst_ch_settled", {62'b0, ch_settled}, 64'd3);
    sb.delete();
    for (int c = 0; c < NUM_CH; c++) g_model[c] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) g_model[c] = 0;
    #1;
    rst_n = 1'b0;
    #1;
    started = 1'b1;
    check("init_out_valid", {63'b0, out_valid}, 64'd0);
    check("init_out_data", {32'b0, out_data}, 64'd0);
    check("init_ch_active", {62'b0, ch_active}, 64'd0);
    check("init_ch_settled", {62'b0, ch_settled}, 64'd3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Off: outputs stay zero and settled.
    repeat (4) drive(1'b1, 2'b00, 16'sd4096, 16'sd4096);
    // Ramp up channel 0 through full scale and hold.
    repeat (20) drive(1'b1, 2'b01, 16'sd4096, 16'sd4096);
    // Ramp back down to off.
    repeat (18) drive(1'b1, 2'b00, 16'sd4096, 16'sd4096);
    // Reversal mid-ramp at g=5.
    repeat (5) drive(1'b1, 2'b01, 16'sd4096, 16'sd4096);
    repeat (6) drive(1'b1, 2'b00, 16'sd4096, 16'sd4096);
    // Sparse strobes, mode wiggled while idle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 4 < 3) ? 2'b11 : 2'b10,
            DATA_W'($urandom), DATA_W'($urandom));
      drive(1'b0, 2'b00, DATA_W'($urandom), DATA_W'($urandom));
      drive(1'b0, 2'b01, DATA_W'($urandom), DATA_W'($urandom));
    end
    repeat (20) drive(1'b1, 2'b00, 16'sd100, -16'sd100);
    // Most negative input: full scale, then down to g=1, then up and reset.
    repeat (17) drive(1'b1, 2'b11, -16'sd32768, -16'sd32768);
    repeat (15) drive(1'b1, 2'b00, -16'sd32768, -16'sd32768);
    repeat (3)  drive(1'b1, 2'b11, -16'sd32768, -16'sd32768);
    reset_now();
    repeat (4) drive(1'b1, 2'b11, -16'sd32768, 16'sd1000);

    // Drain the pipeline with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) drive(1'b0, 2'b00, 16'sd0, 16'sd0);
    repeat (3) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/on_off_channel_ramp.md
Name: on_off_channel_ramp

Overview:
- Parametrised, multi-channel successor of the two-channel on/off gate in the modem datapath.
- Sits between the modulator sample stream and the DAC interface.
- Each channel is switched on or off by its own mode bit. The switch is a linear gain ramp over 2^RAMP_LOG2 valid samples, not a hard cut, which avoids spectral splatter at burst edges.
- Registered output with a fixed two-cycle latency and a valid strobe.

Parameters:
- NUM_CH, 2, number of independent sample channels (e.g. I/Q).
- DATA_W, 16, signed sample width per channel.
- RAMP_LOG2, 4, log2 of ramp length in valid samples; 0 gives an instant switch.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample strobe; one sample per channel per strobe.
- in_data  in  NUM_CH*DATA_W  signed samples; channel c occupies bits [c*DATA_W +: DATA_W].
- mode  in  NUM_CH  per-channel target: 1 = on, 0 = off.
- out_valid  out  1  in_valid delayed by exactly 2 cycles.
- out_data  out  NUM_CH*DATA_W  gated/ramped samples, same packing as in_data.
- ch_active  out  NUM_CH  gain applied to the current out_data is non-zero.
- ch_settled  out  NUM_CH  ramp finished: gain at 0 with mode=0, or at full scale with mode=1.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - All gains = 0; pipeline flushed.
  - out_valid = 0, out_data = 0, ch_active = 0.
  - ch_settled = all ones (gain 0, mode treated as 0).
- Gain state: per-channel counter g, range 0..G_MAX, where G_MAX = 2^RAMP_LOG2 and counter width is RAMP_LOG2+1.
- Counter update, only on cycles with in_valid=1:
  - mode[c]=1 and g<G_MAX: g+1.
  - mode[c]=0 and g>0: g-1.
  - Otherwise: hold.
- mode is ignored on cycles with in_valid=0.
- Gain used for sample k is the value after the update on sample k. The first sample after mode rises is therefore scaled by 1/G_MAX.
- Per-channel states, derived from g and mode:
  - OFF: g=0, mode=0.
  - UP: mode=1, g<G_MAX.
  - ON: g=G_MAX, mode=1.
  - DOWN: mode=0, g>0.
- Reversal mid-ramp: direction follows mode immediately and continues from the current g. No restart, no jump.
- Arithmetic: out = (x * g) >>> RAMP_LOG2.
  - Signed product is DATA_W+RAMP_LOG2+2 bits.
  - Arithmetic shift truncates toward minus infinity.
  - At g=G_MAX the output equals the input bit-exactly, including -2^(DATA_W-1).
  - No saturation is required, since |g/G_MAX| <= 1.
- Pipeline and latency:
  - Stage 1 registers the sample, the updated g and the valid bit.
  - Stage 2 registers the scaled product, out_valid, ch_active and ch_settled.
  - Status outputs are aligned with out_data.
  - Back-to-back in_valid at full clock rate is supported. No backpressure.
- When out_valid=0, out_data holds its last value; consumers qualify with out_valid.
- Channels are fully independent. Simultaneous mode edges on several channels are allowed.
- Reset mid-ramp: immediate asynchronous clear. After release, all channels start from OFF regardless of mode, and ramp up from the first valid sample if mode=1.
- RAMP_LOG2=0: g toggles 0/1, giving a registered hard on/off with 2-cycle latency.

Decomposition:
- Shared package on_off_pkg:
  - ch_state_t enum: OFF, UP, ON, DOWN, used for debug/assertions.
  - Helper function for the product width.
- One sub-module, on_off_ramp_ch: one channel's gain counter, multiply, shift and status bits. The top generate-instantiates NUM_CH copies and fans out in_valid.

Test Plan:
All scenarios use the defaults NUM_CH=2, DATA_W=16, RAMP_LOG2=4.
1. Reset, mode=00, continuous in_valid, in=4096 on both channels -> out_data=0, ch_active=00, ch_settled=11. out_valid rises 2 cycles after the first in_valid.
2. mode=01 with constant in=4096 -> ch0 outputs 256, 512, ..., 4096 on samples 1..16, then holds 4096. ch_settled[0]=1 from sample 16. ch1 stays 0.
3. mode=00 from ON -> ch0 outputs 3840, 3584, ..., 0 over 16 samples. ch_active[0] drops together with the first 0 output.
4. Up for 5 samples (g=5), then mode=00 -> gains 4, 3, 2, 1, 0, giving outputs 1024, 768, 512, 256, 0. No discontinuity.
5. in_valid asserted every 3rd cycle, mode toggled during the gaps -> g advances only on valid samples, and out_valid is in_valid delayed by exactly 2 cycles.
6. in=-32768: g=16 gives -32768 and g=1 gives -2048. Then assert rst_n=0 mid-ramp -> out_valid=0, out_data=0, ch_active=0 immediately; after release, the ramp restarts at g=1.
